// File: rtl/llc_trace_decoder.sv
// LLC trace front-end: decodes one trace command per handshake into cache requests or set sweeps.
// Optional statistics counters are enabled with `define LLC_DEC_STATS_EN.
module llc_trace_decoder #(
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned LINE_SIZE = 64,
  parameter int unsigned NUM_SETS  = 16384,
  localparam int unsigned OFFSET_SIZE = $clog2(LINE_SIZE),
  localparam int unsigned INDEX_SIZE  = $clog2(NUM_SETS),
  localparam int unsigned TAG_SIZE    = ADDR_SIZE - OFFSET_SIZE - INDEX_SIZE
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [3:0]             in_cmd,
  input  logic [ADDR_SIZE-1:0]   in_addr,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [3:0]             out_op,
  output logic [TAG_SIZE-1:0]    out_tag,
  output logic [INDEX_SIZE-1:0]  out_index,
  output logic [OFFSET_SIZE-1:0] out_offset,
  output logic                   out_sweep,
  output logic                   busy,
  output logic                   err_cmd
`ifdef LLC_DEC_STATS_EN
  , output logic [31:0]          stat_reads
  , output logic [31:0]          stat_writes
  , output logic [31:0]          stat_snoops
`endif
);

  typedef enum logic [1:0] {StIdle, StIssue, StSweep} state_e;

  localparam logic [INDEX_SIZE-1:0] LastSet = INDEX_SIZE'(NUM_SETS - 1);

  state_e                state_q;
  logic [INDEX_SIZE-1:0] set_cnt_q;
  logic                  accept;
  logic                  beat;
  logic                  cmd_access;
  logic                  cmd_sweep;

  assign in_ready   = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign accept     = in_valid && in_ready;
  assign beat       = out_valid && out_ready;
  assign cmd_access = (in_cmd <= 4'd6);
  assign cmd_sweep  = (in_cmd == 4'd8) || (in_cmd == 4'd9);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      set_cnt_q  <= '0;
      out_valid  <= 1'b0;
      out_op     <= '0;
      out_tag    <= '0;
      out_index  <= '0;
      out_offset <= '0;
      out_sweep  <= 1'b0;
      err_cmd    <= 1'b0;
    end else begin
      err_cmd <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            if (cmd_access) begin
              out_op     <= in_cmd;
              out_tag    <= in_addr[ADDR_SIZE-1 -: TAG_SIZE];
              out_index  <= in_addr[OFFSET_SIZE +: INDEX_SIZE];
              out_offset <= in_addr[OFFSET_SIZE-1:0];
              out_sweep  <= 1'b0;
              out_valid  <= 1'b1;
              state_q    <= StIssue;
            end else if (cmd_sweep) begin
              out_op     <= in_cmd;
              out_tag    <= '0;
              out_index  <= '0;
              out_offset <= '0;
              out_sweep  <= 1'b1;
              out_valid  <= 1'b1;
              set_cnt_q  <= '0;
              state_q    <= StSweep;
            end else begin
              err_cmd <= 1'b1;
            end
          end
        end
        StIssue: begin
          if (beat) begin
            out_valid <= 1'b0;
            state_q   <= StIdle;
          end
        end
        StSweep: begin
          if (beat) begin
            if (set_cnt_q == LastSet) begin
              // Last set issued: leave without wrapping back to set 0.
              set_cnt_q <= '0;
              out_valid <= 1'b0;
              state_q   <= StIdle;
            end else begin
              set_cnt_q <= set_cnt_q + 1'b1;
              out_index <= set_cnt_q + 1'b1;
            end
          end
        end
        default: begin
          out_valid <= 1'b0;
          state_q   <= StIdle;
        end
      endcase
    end
  end

`ifdef LLC_DEC_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_snoops <= '0;
    end else if (accept) begin
      case (in_cmd)
        4'd0, 4'd2:             stat_reads  <= sat_inc(stat_reads);
        4'd1:                   stat_writes <= sat_inc(stat_writes);
        4'd3, 4'd4, 4'd5, 4'd6: stat_snoops <= sat_inc(stat_snoops);
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_llc_trace_decoder.sv
// Scoreboard bench for llc_trace_decoder: directed scenarios plus randomized commands and back-pressure.
module tb_llc_trace_decoder;

  localparam int NumSets    = 16384;
  localparam int DrainLimit = 40000;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_cmd;
  logic [31:0] in_addr;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_op;
  logic [11:0] out_tag;
  logic [13:0] out_index;
  logic [5:0]  out_offset;
  logic        out_sweep;
  logic        busy;
  logic        err_cmd;
`ifdef LLC_DEC_STATS_EN
  logic [31:0] stat_reads;
  logic [31:0] stat_writes;
  logic [31:0] stat_snoops;
`endif

  always #5 clk = ~clk;

  llc_trace_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_cmd     (in_cmd),
    .in_addr    (in_addr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_op     (out_op),
    .out_tag    (out_tag),
    .out_index  (out_index),
    .out_offset (out_offset),
    .out_sweep  (out_sweep),
    .busy       (busy),
    .err_cmd    (err_cmd)
`ifdef LLC_DEC_STATS_EN
    , .stat_reads  (stat_reads)
    , .stat_writes (stat_writes)
    , .stat_snoops (stat_snoops)
`endif
  );

  typedef struct packed {
    logic [3:0]  op;
    logic [11:0] tag;
    logic [13:0] index;
    logic [5:0]  offset;
    logic        sweep;
  } beat_t;

  beat_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          ready_mode = 1;  // 0 random, 1 held high, 2 held low
  int unsigned m_reads = 0;
  int unsigned m_writes = 0;
  int unsigned m_snoops = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: what the decoder must emit for one accepted command.
  function automatic void model_cmd(input int cmd, input logic [31:0] addr);
    beat_t b;
    if (cmd <= 6) begin
      b.op     = 4'(cmd);
      b.tag    = 12'(addr / 32'd1048576);
      b.index  = 14'((addr / 32'd64) % 32'(NumSets));
      b.offset = 6'(addr % 32'd64);
      b.sweep  = 1'b0;
      exp_q.push_back(b);
      if (cmd == 0 || cmd == 2) m_reads++;
      else if (cmd == 1) m_writes++;
      else m_snoops++;
    end else if (cmd == 8 || cmd == 9) begin
      for (int i = 0; i < NumSets; i++) begin
        b.op     = 4'(cmd);
        b.tag    = '0;
        b.index  = 14'(i);
        b.offset = '0;
        b.sweep  = 1'b1;
        exp_q.push_back(b);
      end
    end
  endfunction

  // Back-pressure driver.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) out_ready = 1'($urandom_range(0, 1));
      else out_ready = (ready_mode == 1);
    end
  end

  // Monitor: pops the scoreboard on every beat and checks stall stability.
  initial begin
    beat_t cur;
    beat_t prev;
    beat_t e;
    logic  stall;
    stall = 1'b0;
    prev  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        cur = {out_op, out_tag, out_index, out_offset, out_sweep};
        if (stall) begin
          check("stall_valid", 64'(out_valid), 64'd1);
          check("stall_hold", 64'(cur), 64'(prev));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_beat: got %0h, required no beat", cur);
          end else begin
            e = exp_q.pop_front();
            check("beat", 64'(cur), 64'(e));
          end
        end
        stall = out_valid && !out_ready;
        prev  = cur;
      end
    end
  end

  task automatic wait_ready();
    for (int i = 0; i < DrainLimit; i++) begin
      @(negedge clk);
      #1;
      if (in_ready) return;
    end
    n_vec++;
    n_err++;
    $display("FAIL ready_timeout: in_ready got 0, required 1");
  endtask

  task automatic send_cmd(input int cmd, input logic [31:0] addr);
    logic legal;
    legal = (cmd <= 6) || (cmd == 8) || (cmd == 9);
    wait_ready();
    in_valid = 1'b1;
    in_cmd   = 4'(cmd);
    in_addr  = addr;
    model_cmd(cmd, addr);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("err_cmd", 64'(err_cmd), 64'(!legal));
    check("latency_valid", 64'(out_valid), 64'(legal));
    check("in_ready_after", 64'(in_ready), 64'(!legal));
    if (legal) check("busy_active", 64'(busy), 64'd1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < DrainLimit; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && in_ready) begin
        check("busy_idle", 64'(busy), 64'd0);
        check("valid_idle", 64'(out_valid), 64'd0);
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL drain_timeout: %0d beats outstanding, required 0", exp_q.size());
    exp_q.delete();
  endtask

  task automatic check_stats();
`ifdef LLC_DEC_STATS_EN
    check("stat_reads", 64'(stat_reads), 64'(m_reads));
    check("stat_writes", 64'(stat_writes), 64'(m_writes));
    check("stat_snoops", 64'(stat_snoops), 64'(m_snoops));
`endif
  endtask

  initial begin
    bit found;
    int c;
    rst      = 1'b1;
    in_valid = 1'b0;
    in_cmd   = '0;
    in_addr  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_err", 64'(err_cmd), 64'd0);
    check("reset_fields", 64'({out_op, out_tag, out_index, out_offset, out_sweep}), 64'd0);
    check_stats();

    // Single access with ready held high.
    send_cmd(0, 32'h1234_5678);
    wait_drain();

    // Write stalled by back-pressure.
    ready_mode = 2;
    @(posedge clk);
    send_cmd(1, 32'hDEAD_BEEF);
    repeat (2) @(negedge clk);
    ready_mode = 1;
    wait_drain();

    // Mixed sequence including a full clear sweep and an illegal opcode.
    send_cmd(0, 32'h0000_0040);
    send_cmd(2, 32'hFFFF_FFFF);
    send_cmd(1, 32'h8000_0001);
    send_cmd(1, 32'h0012_3456);
    send_cmd(3, 32'h7654_3210);
    send_cmd(6, 32'hA5A5_A5A5);
    send_cmd(8, 32'hFFFF_FFFF);
    send_cmd(7, 32'h0000_1000);
    wait_drain();
    check_stats();

    // Illegal opcodes: one-cycle error pulse each.
    send_cmd(7, 32'h1111_1111);
    @(negedge clk);
    #1;
    check("err_pulse_end", 64'(err_cmd), 64'd0);
    send_cmd(15, 32'h2222_2222);
    @(negedge clk);
    #1;
    check("err_pulse_end", 64'(err_cmd), 64'd0);
    check("illegal_ready", 64'(in_ready), 64'd1);

    // Reset in the middle of a print sweep, then restart the sweep.
    send_cmd(9, 32'h0);
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      #1;
      if (out_valid && out_index == 14'd100) found = 1'b1;
    end
    check("sweep_reached_100", 64'(found), 64'd1);
    rst = 1'b1;
    exp_q.delete();
    m_reads  = 0;
    m_writes = 0;
    m_snoops = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_sweep_valid", 64'(out_valid), 64'd0);
    check("rst_sweep_busy", 64'(busy), 64'd0);
    check("rst_sweep_ready", 64'(in_ready), 64'd1);
    check_stats();
    send_cmd(9, 32'h0);
    wait_drain();

    // Randomized commands under random back-pressure.
    ready_mode = 0;
    for (int n = 0; n < 200; n++) begin
      c = int'($urandom_range(0, 15));
      if (c == 8 || c == 9) c = c - 8;
      send_cmd(c, $urandom);
    end
    wait_drain();
    ready_mode = 1;
    check_stats();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
